// File: rtl/my_pkg.sv
// Shared types and defaults for the memory-port arbiter.
package my_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_FETCH,
    ARB_DATA
  } arb_state_t;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// one transaction in flight, with a starvation guard for fetch.
module mem_arbiter
  import my_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  arb_state_t    state;
  logic [CW-1:0] starve_cnt;

  logic i_pend, d_pend, busy, done, arb_en, starved, fetch_win, data_win;

  // A requester whose gnt is high this cycle is still showing the request
  // that was just accepted, so it must not be granted a second time.
  always_comb begin
    i_pend    = i_req & ~i_gnt;
    d_pend    = d_req & ~d_gnt;
    busy      = (state != ARB_IDLE);
    done      = busy & mem_ready;
    arb_en    = (state == ARB_IDLE) | done;
    starved   = (starve_cnt == CW'(STARVE_LIMIT));
    fetch_win = arb_en & i_pend & (~d_pend | starved);
    data_win  = arb_en & d_pend & ~(i_pend & starved);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      i_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      i_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      i_gnt    <= fetch_win;
      d_gnt    <= data_win;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;

      if (done) begin
        if (state == ARB_FETCH) begin
          i_rvalid <= 1'b1;
          i_rdata  <= mem_rdata;
        end else begin
          d_rvalid <= 1'b1;
          if (mem_we == '0) d_rdata <= mem_rdata;
        end
      end

      if (fetch_win) begin
        state      <= ARB_FETCH;
        mem_en     <= 1'b1;
        mem_we     <= '0;
        mem_addr   <= i_addr;
        mem_wdata  <= '0;
        starve_cnt <= '0;
      end else if (data_win) begin
        state     <= ARB_DATA;
        mem_en    <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        if (i_pend && !starved) starve_cnt <= starve_cnt + CW'(1);
      end else if (arb_en) begin
        state  <= ARB_IDLE;
        mem_en <= 1'b0;
        mem_we <= '0;
      end
    end
  end

endmodule
